// File: rtl/tile_fetch.sv
// tile_fetch: reads a stored frame from SRAM in tile order and streams its pixels to the DWT.
//
// Tiles are visited in raster order. Inside each tile, the block reads one row of words at a time,
// top row first. Each 32-bit SRAM word is sent as four pixels, most significant byte first.
// Read data returns RD_LAT cycles after the address is driven. It lands in a 4-word FIFO.
// New reads are throttled so that the reads in flight plus the FIFO fill never exceed 4.
//
// Ports:
//   clk_100          in   system clock, rising edge
//   rst              in   asynchronous active-low reset
//   jpeg_start       in   one-cycle pulse: frame is stored, begin fetching
//   data_to_jpeg     in   SRAM read word (pixel order [31:24],[23:16],[15:8],[7:0])
//   address_from_dwt out  SRAM word read address (0 when not fetching)
//   pix_data         out  pixel to DWT
//   pix_valid        out  pix_data valid
//   pix_ready        in   DWT accepts pixel
//   tile_last        out  marks the last pixel of each tile
//   frame_done       out  one-cycle pulse once the whole frame has been transferred
//
// Build option: define TILE_FETCH_LEVEL_SHIFT_EN to flip the pixel MSB.
// This applies the DC level shift and makes pixels two's complement.
// When the macro is undefined, raw bytes are passed through.
module tile_fetch #(
  parameter int unsigned IMG_WPR   = 160,
  parameter int unsigned IMG_ROWS  = 480,
  parameter int unsigned TILE_WW   = 8,
  parameter int unsigned TILE_ROWS = 32,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        jpeg_start,
  input  logic [31:0] data_to_jpeg,
  output logic [17:0] address_from_dwt,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        tile_last,
  output logic        frame_done
);

  localparam int unsigned NumCols = IMG_WPR / TILE_WW;
  localparam int unsigned NumTrows = IMG_ROWS / TILE_ROWS;
  localparam logic [15:0] WordMax = 16'(TILE_WW - 1);
  localparam logic [15:0] RowMax = 16'(TILE_ROWS - 1);
  localparam logic [15:0] ColMax = 16'(NumCols - 1);
  localparam logic [15:0] TrowMax = 16'(NumTrows - 1);
  localparam logic [17:0] RowStep = 18'(IMG_WPR);
  localparam logic [17:0] TileStep = 18'(TILE_WW);
  localparam logic [17:0] TrowStep = 18'(TILE_ROWS * IMG_WPR);

`ifdef TILE_FETCH_LEVEL_SHIFT_EN
  localparam logic [7:0] LevelMask = 8'h80;
`else
  localparam logic [7:0] LevelMask = 8'h00;
`endif

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [15:0] word_q, row_q, tcol_q, trow_q;
  logic [17:0] addr_q, row_base_q, tile_base_q, trow_base_q;
  logic        end_word, end_row, end_col, end_trow, last_read, tile_end;

  logic [RD_LAT-1:0] sr_q, sr_d, tag_sr_q, tag_sr_d;
  logic [4:0]        occ;
  logic              issue;

  logic [32:0] fifo_mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q, idx_q;
  logic [2:0]  cnt_q;
  logic        fifo_wr, fire, pop;
  logic [32:0] head;
  logic [7:0]  raw_byte;

  assign end_word  = (word_q == WordMax);
  assign end_row   = (row_q == RowMax);
  assign end_col   = (tcol_q == ColMax);
  assign end_trow  = (trow_q == TrowMax);
  assign tile_end  = end_word && end_row;
  assign last_read = tile_end && end_col && end_trow;

  // Reads in flight plus FIFO fill, so the FIFO can never be overrun.
  assign occ   = 5'($countones(sr_q)) + {2'b00, cnt_q};
  assign issue = (state_q == StFetch) && (occ < 5'd4);

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle:  if (jpeg_start) state_d = StFetch;
      StFetch: if (issue && last_read) state_d = StDrain;
      StDrain: if ((cnt_q == 3'd0) && (sr_q == '0)) state_d = StDone;
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Incremental address walk. Each base register holds the start address of its own scope,
  // so every step is a single add.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      word_q      <= '0;
      row_q       <= '0;
      tcol_q      <= '0;
      trow_q      <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      tile_base_q <= '0;
      trow_base_q <= '0;
    end else if ((state_q == StIdle) && jpeg_start) begin
      word_q      <= '0;
      row_q       <= '0;
      tcol_q      <= '0;
      trow_q      <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      tile_base_q <= '0;
      trow_base_q <= '0;
    end else if (issue && !last_read) begin
      if (!end_word) begin
        word_q <= word_q + 16'd1;
        addr_q <= addr_q + 18'd1;
      end else if (!end_row) begin
        word_q     <= '0;
        row_q      <= row_q + 16'd1;
        row_base_q <= row_base_q + RowStep;
        addr_q     <= row_base_q + RowStep;
      end else if (!end_col) begin
        word_q      <= '0;
        row_q       <= '0;
        tcol_q      <= tcol_q + 16'd1;
        tile_base_q <= tile_base_q + TileStep;
        row_base_q  <= tile_base_q + TileStep;
        addr_q      <= tile_base_q + TileStep;
      end else begin
        word_q      <= '0;
        row_q       <= '0;
        tcol_q      <= '0;
        trow_q      <= trow_q + 16'd1;
        trow_base_q <= trow_base_q + TrowStep;
        tile_base_q <= trow_base_q + TrowStep;
        row_base_q  <= trow_base_q + TrowStep;
        addr_q      <= trow_base_q + TrowStep;
      end
    end
  end

  assign address_from_dwt = (state_q == StFetch) ? addr_q : '0;

  // Valid/tag pipeline that tracks each issued read until its data comes back.
  generate
    if (RD_LAT == 1) begin : g_lat_one
      assign sr_d     = issue;
      assign tag_sr_d = issue && tile_end;
    end else begin : g_lat_many
      assign sr_d     = {sr_q[RD_LAT-2:0], issue};
      assign tag_sr_d = {tag_sr_q[RD_LAT-2:0], issue && tile_end};
    end
  endgenerate

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      sr_q     <= '0;
      tag_sr_q <= '0;
    end else begin
      sr_q     <= sr_d;
      tag_sr_q <= tag_sr_d;
    end
  end

  assign fifo_wr = sr_q[RD_LAT-1];

  // Each FIFO entry is stored as {tile_end tag, word}.
  always_ff @(posedge clk_100) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= {tag_sr_q[RD_LAT-1], data_to_jpeg};
  end

  assign head      = fifo_mem_q[rd_ptr_q];
  assign pix_valid = (cnt_q != 3'd0);
  assign fire      = pix_valid && pix_ready;
  assign pop       = fire && (idx_q == 2'd3);

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      if (fire)    idx_q    <= idx_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, fifo_wr} - {2'b00, pop};
    end
  end

  // The pixel is taken straight from the FIFO head, so it holds steady while stalled.
  always_comb begin
    raw_byte = 8'h00;
    unique case (idx_q)
      2'd0: raw_byte = head[31:24];
      2'd1: raw_byte = head[23:16];
      2'd2: raw_byte = head[15:8];
      2'd3: raw_byte = head[7:0];
      default: raw_byte = 8'h00;
    endcase
  end

  assign pix_data  = pix_valid ? (raw_byte ^ LevelMask) : 8'h00;
  assign tile_last = pix_valid && head[32] && (idx_q == 2'd3);

endmodule
